// File: rtl/loop_trace_pkg.sv
// Shared definitions for the loop trace checker.
// Holds the checker state encoding, the violation code values and the
// width of the gap counter, plus a helper that resolves simultaneous
// violations to the single code that is reported.
package loop_trace_pkg;

    localparam int GAP_W = 9;
    localparam logic [GAP_W-1:0] GAP_MAX = 9'h1FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_A1    = 3'd2,
        ST_GAP   = 3'd3,
        ST_CLR   = 3'd4,
        ST_START = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_VALUE  = 2'd1;
    localparam logic [1:0] ERR_TIMING = 2'd2;
    localparam logic [1:0] ERR_CLEAR  = 2'd3;

    // When several checks fail on the same sample only the most severe
    // code is reported: clear > timing > value.
    function automatic logic [1:0] pick_err(input logic val_bad,
                                            input logic time_bad,
                                            input logic clr_bad);
        logic [1:0] code;
        if (clr_bad) begin
            code = ERR_CLEAR;
        end else if (time_bad) begin
            code = ERR_TIMING;
        end else if (val_bad) begin
            code = ERR_VALUE;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/loop_trace_edge.sv
// Input sampling stage for the loop trace checker.
// Registers act1/act2 once, keeps the previous sample, and reports a
// change strobe per action whenever the two registered samples differ.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   act1, act2            raw observed action values
//   act1_cur, act2_cur    registered (current) samples
//   act2_prev             sample of act2 one cycle before act2_cur
//   chg1, chg2            change strobes for act1 / act2
module loop_trace_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] act1,
    input  logic [7:0] act2,
    output logic [7:0] act1_cur,
    output logic [7:0] act2_cur,
    output logic [7:0] act2_prev,
    output logic       chg1,
    output logic       chg2
);

    logic [7:0] act1_q;
    logic [7:0] act1_d;
    logic [7:0] act2_q;
    logic [7:0] act2_d;
    logic [7:0] act1_prev_q;
    logic [7:0] act1_prev_d;
    logic [7:0] act2_prev_q;
    logic [7:0] act2_prev_d;

    // Next-state for the two-deep sample pipeline.
    always_comb begin
        act1_d      = act1;
        act2_d      = act2;
        act1_prev_d = act1_q;
        act2_prev_d = act2_q;
    end

    // Sample pipeline registers; reset clears the remembered trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act1_q      <= 8'd0;
            act2_q      <= 8'd0;
            act1_prev_q <= 8'd0;
            act2_prev_q <= 8'd0;
        end else begin
            act1_q      <= act1_d;
            act2_q      <= act2_d;
            act1_prev_q <= act1_prev_d;
            act2_prev_q <= act2_prev_d;
        end
    end

    assign act1_cur  = act1_q;
    assign act2_cur  = act2_q;
    assign act2_prev = act2_prev_q;
    assign chg1      = (act1_q != act1_prev_q);
    assign chg2      = (act2_q != act2_prev_q);

endmodule

// File: rtl/loop_trace_checker.sv
// Loop trace checker.
// Follows a nested-loop action trace: act2 steps 1..OUTER_N (one outer
// step every INNER_N+2 cycles), each act2 step is followed one cycle later
// by act1 taking the same value, and a frame ends with act1/act2 both
// returning to 0 exactly INNER_N+3 cycles after the last act2 step,
// immediately followed by the next frame's act2 0->1.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           checking enable (0 forces IDLE)
//   act1, act2   observed inner / outer loop action values
//   state        current checker state code
//   outer_cnt    act2 value currently tracked
//   gap_cnt      cycles since the last accepted act2/clear event
//   frame_ok     one-cycle pulse on a clean frame completion
//   frame_cnt    clean frame count, saturating
//   err          one-cycle violation pulse
//   err_code     last violation: 0 none, 1 value, 2 timing, 3 clear
//   err_seen     sticky violation flag
// Build option: define LOOP_TRACE_TIMING_EN to enforce the gap positions
// (code 2); without it only value, order and clear checks are made.
module loop_trace_checker
    import loop_trace_pkg::*;
#(
    parameter int OUTER_N = 10,
    parameter int INNER_N = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  act1,
    input  logic [7:0]  act2,
    output logic [2:0]  state,
    output logic [7:0]  outer_cnt,
    output logic [8:0]  gap_cnt,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        err_seen
);

`ifdef LOOP_TRACE_TIMING_EN
    localparam logic TIMING_EN = 1'b1;
`else
    localparam logic TIMING_EN = 1'b0;
`endif

    localparam logic [GAP_W-1:0] GAP_STEP   = GAP_W'(INNER_N + 2);
    localparam logic [GAP_W-1:0] GAP_CLEAR  = GAP_W'(INNER_N + 3);
    localparam logic [7:0]       OUTER_LAST = 8'(OUTER_N);

    logic [7:0] act1_cur;
    logic [7:0] act2_cur;
    logic [7:0] act2_prev;
    logic       chg1;
    logic       chg2;

    loop_trace_edge u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .act1      (act1),
        .act2      (act2),
        .act1_cur  (act1_cur),
        .act2_cur  (act2_cur),
        .act2_prev (act2_prev),
        .chg1      (chg1),
        .chg2      (chg2)
    );

    state_e             state_q;
    state_e             state_d;
    logic [7:0]         outer_q;
    logic [7:0]         outer_d;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_d;
    logic               frame_ok_q;
    logic               frame_ok_d;
    logic [15:0]        frame_cnt_q;
    logic [15:0]        frame_cnt_d;
    logic               err_q;
    logic               err_d;
    logic [1:0]         err_code_q;
    logic [1:0]         err_code_d;
    logic               err_seen_q;
    logic               err_seen_d;

    logic               bad_val;
    logic               bad_time;
    logic               bad_clr;
    logic               start_ev;
    logic [GAP_W-1:0]   gap_inc;

    // A frame (re)starts only on act2 going 0->1 while act1 sits at 0.
    assign start_ev = chg2 && (act2_cur == 8'd1) && (act2_prev == 8'd0)
                      && (act1_cur == 8'd0);
    // gap_inc is the gap count including the current cycle.
    assign gap_inc  = (gap_q == GAP_MAX) ? gap_q : gap_q + 9'd1;

    // Trace checking: next state, counters and violation reporting.
    always_comb begin
        state_d     = state_q;
        outer_d     = outer_q;
        gap_d       = gap_q;
        frame_ok_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        err_seen_d  = err_seen_q;
        bad_val     = 1'b0;
        bad_time    = 1'b0;
        bad_clr     = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            outer_d = 8'd0;
            gap_d   = 9'd0;
        end else begin
            if ((state_q != ST_IDLE) && (state_q != ST_SYNC)) begin
                gap_d = gap_inc;
            end else begin
                gap_d = gap_q;
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (start_ev) begin
                        outer_d = 8'd1;
                        gap_d   = 9'd0;
                        state_d = ST_A1;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_A1: begin
                    // act1 must follow act2 on exactly this sample.
                    if (chg1 && !chg2 && (act1_cur == outer_q)) begin
                        state_d = (outer_q == OUTER_LAST) ? ST_CLR : ST_GAP;
                    end else begin
                        bad_val = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (chg1) begin
                        bad_val = 1'b1;
                    end else begin
                        bad_val = 1'b0;
                    end
                    if (chg2) begin
                        if (act2_cur != outer_q + 8'd1) begin
                            bad_val = 1'b1;
                        end else begin
                            outer_d = outer_q + 8'd1;
                        end
                        bad_time = TIMING_EN && (gap_inc != GAP_STEP);
                        gap_d    = 9'd0;
                        state_d  = ST_A1;
                    end else begin
                        bad_time = TIMING_EN && (gap_inc > GAP_STEP);
                    end
                end
                ST_CLR: begin
                    if (chg1 || chg2) begin
                        bad_clr  = !(chg1 && chg2) || (act1_cur != 8'd0)
                                   || (act2_cur != 8'd0);
                        bad_time = TIMING_EN && (gap_inc != GAP_CLEAR);
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = (frame_cnt_q == 16'hFFFF) ?
                                      frame_cnt_q : frame_cnt_q + 16'd1;
                        outer_d     = 8'd0;
                        gap_d       = 9'd0;
                        state_d     = ST_START;
                    end else begin
                        bad_time = TIMING_EN && (gap_inc > GAP_CLEAR);
                    end
                end
                ST_START: begin
                    if (start_ev) begin
                        outer_d = 8'd1;
                        gap_d   = 9'd0;
                        state_d = ST_A1;
                    end else begin
                        bad_time = TIMING_EN;
                        bad_val  = chg1 || chg2;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    outer_d = 8'd0;
                    gap_d   = 9'd0;
                end
            endcase

            // Any violation abandons the frame and discards the tentative
            // success updates made above.
            if (bad_val || bad_time || bad_clr) begin
                err_d       = 1'b1;
                err_code_d  = pick_err(bad_val, bad_time, bad_clr);
                err_seen_d  = 1'b1;
                frame_ok_d  = 1'b0;
                frame_cnt_d = frame_cnt_q;
                outer_d     = 8'd0;
                gap_d       = 9'd0;
                state_d     = ST_SYNC;
            end else begin
                err_d = 1'b0;
            end
        end
    end

    // Checker state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            outer_q     <= 8'd0;
            gap_q       <= 9'd0;
            frame_ok_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            outer_q     <= outer_d;
            gap_q       <= gap_d;
            frame_ok_q  <= frame_ok_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_seen_q  <= err_seen_d;
        end
    end

    assign state     = state_q;
    assign outer_cnt = outer_q;
    assign gap_cnt   = gap_q;
    assign frame_ok  = frame_ok_q;
    assign frame_cnt = frame_cnt_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_loop_trace_checker.sv
// Self-checking bench for loop_trace_checker.
// A trace generator emits whole frames (optionally with one injected
// fault); for each frame the expected outcome (clean completion or a
// violation code) is pushed to a queue, and a monitor pops and compares
// whenever the DUT pulses err or frame_ok.
module tb_loop_trace_checker;

    localparam int OUTER_N = 10;
    localparam int INNER_N = 10;

`ifdef LOOP_TRACE_TIMING_EN
    localparam bit TIMING = 1'b1;
`else
    localparam bit TIMING = 1'b0;
`endif

    localparam int F_NONE  = 0;
    localparam int F_VAL   = 1;
    localparam int F_ACT1  = 2;
    localparam int F_DELAY = 3;
    localparam int F_CLEAR = 4;
    localparam int F_RESET = 5;
    localparam int F_EN    = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  act1 = 8'd0;
    logic [7:0]  act2 = 8'd0;
    logic [2:0]  state;
    logic [7:0]  outer_cnt;
    logic [8:0]  gap_cnt;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic        err;
    logic [1:0]  err_code;
    logic        err_seen;

    always #5 clk = ~clk;

    loop_trace_checker #(.OUTER_N(OUTER_N), .INNER_N(INNER_N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .act1      (act1),
        .act2      (act2),
        .state     (state),
        .outer_cnt (outer_cnt),
        .gap_cnt   (gap_cnt),
        .frame_ok  (frame_ok),
        .frame_cnt (frame_cnt),
        .err       (err),
        .err_code  (err_code),
        .err_seen  (err_seen)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [15:0] fcnt;
        bit          seen;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   model_frames = 0;
    bit   model_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the outcome of one frame follows from its fault.
    task automatic expect_for(input int fault);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = 2'd0;
        case (fault)
            F_NONE:         e.is_err = 1'b0;
            F_VAL, F_ACT1:  begin e.is_err = 1'b1; e.code = 2'd1; end
            F_DELAY:        begin e.is_err = TIMING; e.code = TIMING ? 2'd2 : 2'd0; end
            F_CLEAR:        begin e.is_err = 1'b1; e.code = 2'd3; end
            default:        return;
        endcase
        if (e.is_err) begin
            model_seen = 1'b1;
        end else if (model_frames < 65535) begin
            model_frames++;
        end
        e.fcnt = 16'(model_frames);
        e.seen = model_seen;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] a1, input logic [7:0] a2);
        act1 = a1;
        act2 = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_outer_cnt", 32'(outer_cnt), 32'd0);
        check("rst_gap_cnt", 32'(gap_cnt), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_seen", 32'(err_seen), 32'd0);
        model_frames = 0;
        model_seen   = 1'b0;
        rst_n = 1'b1;
    endtask

    // One frame of the nested-loop trace: per outer step k, act2=k, then
    // act1=k next cycle, then hold; a simultaneous clear ends the frame.
    task automatic run_frame(input int fault, input int pos);
        logic [7:0] a1;
        logic [7:0] v2;
        int         hold;
        a1 = 8'd0;
        expect_for(fault);
        for (int k = 1; k <= OUTER_N; k++) begin
            hold = (k == OUTER_N) ? INNER_N + 1 : INNER_N;
            v2 = 8'(k);
            if (fault == F_DELAY && k == pos) cyc(a1, act2);
            if (fault == F_VAL && k == pos) v2 = 8'(k + 1);
            cyc(a1, v2);
            if (fault == F_RESET && k == pos) reset_pulse();
            a1 = 8'(k);
            cyc(a1, v2);
            for (int h = 0; h < hold; h++) begin
                if (fault == F_ACT1 && k == pos && h == 4) a1 = 8'(k + 100);
                if (fault == F_EN && k == pos && h == 2) en = 1'b0;
                if (fault == F_EN && k == pos && h == 5) en = 1'b1;
                cyc(a1, v2);
                if (fault == F_EN && k == pos && h == 2) begin
                    check("en_drop_state", 32'(state), 32'd0);
                    check("en_drop_outer_cnt", 32'(outer_cnt), 32'd0);
                    check("en_drop_err", 32'(err), 32'd0);
                end
            end
        end
        cyc(8'd0, (fault == F_CLEAR) ? 8'(OUTER_N) : 8'd0);
        if (fault == F_CLEAR) cyc(8'd0, 8'd0);
    endtask

    // Monitor: every err/frame_ok pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && (err || frame_ok)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: err=%0d code=%0d frame_ok=%0d, expected none (t=%0t)",
                         err, err_code, frame_ok, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'd0, err, frame_ok},
                      mon_e.is_err ? 32'd2 : 32'd1);
                check("err_seen", 32'(err_seen), 32'(mon_e.seen));
                if (mon_e.is_err) begin
                    check("err_code", 32'(err_code), 32'(mon_e.code));
                    check("state_after_err", 32'(state), 32'd1);
                end else begin
                    check("frame_cnt", 32'(frame_cnt), 32'(mon_e.fcnt));
                end
            end
        end
    end

    initial begin
        int f;
        int p;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_state", 32'(state), 32'd0);
        check("init_frame_cnt", 32'(frame_cnt), 32'd0);
        check("init_err_seen", 32'(err_seen), 32'd0);
        check("init_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(8'd0, 8'd0);
        check("sync_after_en", 32'(state), 32'd1);
        cyc(8'd0, 8'd0);

        repeat (3) run_frame(F_NONE, 0);
        run_frame(F_VAL, 5);
        run_frame(F_NONE, 0);
        run_frame(F_DELAY, 6);
        run_frame(F_NONE, 0);
        run_frame(F_CLEAR, 0);
        run_frame(F_NONE, 0);
        run_frame(F_RESET, 5);
        run_frame(F_NONE, 0);
        run_frame(F_EN, 4);
        run_frame(F_NONE, 0);

        for (int i = 0; i < 8; i++) begin
            f = int'($urandom_range(0, 4));
            case (f)
                F_VAL:   p = int'($urandom_range(2, OUTER_N - 1));
                F_ACT1:  p = int'($urandom_range(1, OUTER_N - 1));
                F_DELAY: p = int'($urandom_range(2, OUTER_N));
                default: p = 0;
            endcase
            run_frame(f, p);
        end

        // Let the last frame complete, then park in IDLE.
        cyc(8'd0, 8'd0);
        en = 1'b0;
        repeat (5) cyc(8'd0, 8'd0);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        check("final_frame_cnt", 32'(frame_cnt), 32'(model_frames));
        check("final_err_seen", 32'(err_seen), 32'(model_seen));
        check("final_state_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
